// File: rtl/pcie_framing_pkg.sv
// Shared types, symbol constants and DW builder for the Gen3 framing-token scheduler.
package pcie_framing_pkg;

  typedef enum logic [1:0] {
    TOK_STP = 2'd0,
    TOK_SDP = 2'd1,
    TOK_EDB = 2'd2,
    TOK_EDS = 2'd3
  } tok_type_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } sched_state_e;

  // Byte 0 of every DW sits in bits [7:0] and goes out first, on the lowest lane.
  localparam logic [7:0]  SDP_B0 = 8'hF0;
  localparam logic [7:0]  SDP_B1 = 8'hAC;
  localparam logic [7:0]  EDB_B  = 8'hC0;
  localparam logic [31:0] EDS_DW = 32'h0090801F;
  localparam logic [7:0]  IDL_B  = 8'h00;
  localparam logic [31:0] IDL_DW = {4{IDL_B}};

  localparam int SYMS_PER_BLOCK = 16;

  // FIFO entry: {type[1:0], payload[31:0]}
  localparam int ENTRY_W = 34;

  // Turn a queued request into the four symbols it occupies on the wire.
  function automatic logic [31:0] build_dw(input tok_type_e t, input logic [31:0] p);
    case (t)
      TOK_STP: build_dw = {p[31:4], 4'hF};
      TOK_SDP: build_dw = {p[31:24], p[23:16], SDP_B1, SDP_B0};
      TOK_EDB: build_dw = {4{EDB_B}};
      default: build_dw = EDS_DW;
    endcase
  endfunction

endpackage

// File: rtl/pcie_framing_token_scheduler_fifo.sv
// Token request FIFO: one push per cycle, up to SLOTS pops, head SLOTS entries visible.
module pcie_tok_fifo
  import pcie_framing_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SLOTS = 4,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PCW  = $clog2(SLOTS + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  logic [ENTRY_W-1:0]              push_data,
  input  logic [PCW-1:0]                  pop_cnt,
  output logic [SLOTS-1:0][ENTRY_W-1:0]   peek_data,
  output logic [SLOTS-1:0]                peek_vld,
  output logic                            ready,
  output logic [CW-1:0]                   level
);

  localparam int PW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr_reg;
  logic [PW-1:0]      rd_ptr_reg;
  logic [CW-1:0]      count_reg;
  logic               push_ok;

  // Ready depends only on the stored count, never on a same-cycle pop.
  assign ready   = count_reg < CW'(DEPTH);
  assign push_ok = push && ready;
  assign level   = count_reg;

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      rd_ptr_reg <= rd_ptr_reg + PW'(pop_cnt);
      count_reg  <= count_reg + CW'(push_ok) - CW'(pop_cnt);
    end
  end

  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_peek
    assign peek_data[gi] = mem[rd_ptr_reg + PW'(gi)];
    assign peek_vld[gi]  = int'(count_reg) > gi;
  end

endmodule

// File: rtl/pcie_framing_token_scheduler.sv
// Gen3 framing-token scheduler: DW-aligned token placement, IDL fill, EDS/block tracking.
module pcie_framing_token_scheduler
  import pcie_framing_pkg::*;
#(
  parameter int LANES = 16,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         tok_valid,
  output logic                         tok_ready,
  input  logic [1:0]                   tok_type,
  input  logic [31:0]                  tok_payload,
  input  logic                         resume,
  output logic [LANES*8-1:0]           out_data,
  output logic                         out_valid,
  output logic                         out_sob,
  output logic                         out_eds,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

  localparam int SLOTS = (LANES >= 4) ? LANES / 4 : 1;
  localparam int PCW   = $clog2(SLOTS + 1);

  sched_state_e                  state_reg, state_next;
  logic [3:0]                    sym_cnt_reg, sym_cnt_next;
  logic [LANES*8-1:0]            out_data_next;
  logic                          out_valid_next, out_sob_next, out_eds_next;
  logic                          advance;
  logic [LANES*8-1:0]            run_data;
  logic [PCW-1:0]                run_pop;
  logic                          run_eds;
  logic [SLOTS-1:0][ENTRY_W-1:0] peek_data;
  logic [SLOTS-1:0]              peek_vld;

  pcie_tok_fifo #(.DEPTH(DEPTH), .SLOTS(SLOTS)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tok_valid),
    .push_data ({tok_type, tok_payload}),
    .pop_cnt   (advance ? run_pop : '0),
    .peek_data (peek_data),
    .peek_vld  (peek_vld),
    .ready     (tok_ready),
    .level     (fifo_level)
  );

  if (LANES >= 4) begin : g_wide
    logic blocked;

    // Fill slots in FIFO order; a head EDS either jumps to the last slot at
    // the block's final symbol time or stalls everything behind it.
    always_comb begin
      run_data = '0;
      run_pop  = '0;
      run_eds  = 1'b0;
      blocked  = 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        if (!blocked && peek_vld[i]) begin
          if (tok_type_e'(peek_data[i][33:32]) == TOK_EDS) begin
            blocked = 1'b1;
            if (sym_cnt_reg == 4'(SYMS_PER_BLOCK - 1)) begin
              run_data[(SLOTS-1)*32 +: 32] = EDS_DW;
              run_pop  = run_pop + PCW'(1);
              run_eds  = 1'b1;
            end
          end else begin
            run_data[i*32 +: 32] = build_dw(tok_type_e'(peek_data[i][33:32]), peek_data[i][31:0]);
            run_pop  = run_pop + PCW'(1);
          end
        end else begin
          blocked = 1'b1;
        end
      end
    end
  end else begin : g_narrow
    localparam int DW_CYC = 4 / LANES;
    localparam int PTRW   = $clog2(DW_CYC);
    localparam int W      = LANES * 8;

    logic [PTRW-1:0] ptr_reg;
    logic [31:0]     dw_reg;
    logic            eds_reg;
    tok_type_e       head_type;
    logic            head_eds, head_ok, cur_eds;
    logic [31:0]     head_dw, cur_dw;

    // At byte 0 a fresh DW is taken from the head (EDS only if it ends the block);
    // later bytes come from the latched DW.
    always_comb begin
      head_type = tok_type_e'(peek_data[0][33:32]);
      head_eds  = (head_type == TOK_EDS);
      head_ok   = peek_vld[0] && (!head_eds || sym_cnt_reg == 4'(SYMS_PER_BLOCK - DW_CYC));
      head_dw   = head_ok ? build_dw(head_type, peek_data[0][31:0]) : IDL_DW;
      cur_dw    = (ptr_reg == '0) ? head_dw : dw_reg;
      cur_eds   = (ptr_reg == '0) ? (head_ok && head_eds) : eds_reg;
      run_data  = cur_dw[int'(ptr_reg)*W +: W];
      run_pop   = PCW'((ptr_reg == '0) && head_ok);
      run_eds   = cur_eds && (ptr_reg == PTRW'(DW_CYC - 1));
    end

    // Byte pointer and latched DW; a reset discards any half-sent DW.
    always_ff @(posedge clk) begin
      if (rst) begin
        ptr_reg <= '0;
        dw_reg  <= IDL_DW;
        eds_reg <= 1'b0;
      end else if (advance) begin
        ptr_reg <= (ptr_reg == PTRW'(DW_CYC - 1)) ? '0 : ptr_reg + PTRW'(1);
        if (ptr_reg == '0) begin
          dw_reg  <= head_dw;
          eds_reg <= head_ok && head_eds;
        end
      end
    end
  end

  // State, block position and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_RUN;
      sym_cnt_reg <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_sob     <= 1'b0;
      out_eds     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      sym_cnt_reg <= sym_cnt_next;
      out_data    <= out_data_next;
      out_valid   <= out_valid_next;
      out_sob     <= out_sob_next;
      out_eds     <= out_eds_next;
    end
  end

  // RUN emits one symbol time per en; completing EDS parks in HOLD until resume.
  always_comb begin
    state_next     = state_reg;
    sym_cnt_next   = sym_cnt_reg;
    out_data_next  = out_data;
    out_valid_next = 1'b0;
    out_sob_next   = 1'b0;
    out_eds_next   = 1'b0;
    advance        = 1'b0;
    case (state_reg)
      ST_RUN: begin
        if (en) begin
          advance        = 1'b1;
          out_valid_next = 1'b1;
          out_data_next  = run_data;
          out_sob_next   = (sym_cnt_reg == '0);
          if (run_eds) begin
            out_eds_next = 1'b1;
            state_next   = ST_HOLD;
            sym_cnt_next = '0;
          end else begin
            sym_cnt_next = sym_cnt_reg + 4'd1;
          end
        end
      end
      ST_HOLD: begin
        out_data_next = '0;
        if (resume) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

endmodule

// File: tb/tb_pcie_framing_token_scheduler.sv
// Scoreboard bench: four scheduler instances (x16, x8, x1 depth 4, x2) exercised per scenario.
module tb_pcie_framing_token_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [127:0] data;
    logic         sob;
    logic         eds;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] sb_b[$];
  int         c_sym = 0;
  logic       en_pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  // Instance A: x16, depth 8
  logic a_rst, a_en, a_tok_valid, a_tok_ready, a_resume, a_out_valid, a_out_sob, a_out_eds;
  logic [1:0] a_tok_type; logic [31:0] a_tok_payload; logic [127:0] a_out_data; logic [3:0] a_fifo_level;
  // Instance B: x8, depth 8
  logic b_rst, b_en, b_tok_valid, b_tok_ready, b_resume, b_out_valid, b_out_sob, b_out_eds;
  logic [1:0] b_tok_type; logic [31:0] b_tok_payload; logic [63:0] b_out_data; logic [3:0] b_fifo_level;
  // Instance C: x1, depth 4
  logic c_rst, c_en, c_tok_valid, c_tok_ready, c_resume, c_out_valid, c_out_sob, c_out_eds;
  logic [1:0] c_tok_type; logic [31:0] c_tok_payload; logic [7:0] c_out_data; logic [2:0] c_fifo_level;
  // Instance D: x2, depth 8
  logic d_rst, d_en, d_tok_valid, d_tok_ready, d_resume, d_out_valid, d_out_sob, d_out_eds;
  logic [1:0] d_tok_type; logic [31:0] d_tok_payload; logic [15:0] d_out_data; logic [3:0] d_fifo_level;

  pcie_framing_token_scheduler #(.LANES(16), .DEPTH(8)) u_a (
    .clk(clk), .rst(a_rst), .en(a_en), .tok_valid(a_tok_valid), .tok_ready(a_tok_ready),
    .tok_type(a_tok_type), .tok_payload(a_tok_payload), .resume(a_resume), .out_data(a_out_data),
    .out_valid(a_out_valid), .out_sob(a_out_sob), .out_eds(a_out_eds), .fifo_level(a_fifo_level));
  pcie_framing_token_scheduler #(.LANES(8), .DEPTH(8)) u_b (
    .clk(clk), .rst(b_rst), .en(b_en), .tok_valid(b_tok_valid), .tok_ready(b_tok_ready),
    .tok_type(b_tok_type), .tok_payload(b_tok_payload), .resume(b_resume), .out_data(b_out_data),
    .out_valid(b_out_valid), .out_sob(b_out_sob), .out_eds(b_out_eds), .fifo_level(b_fifo_level));
  pcie_framing_token_scheduler #(.LANES(1), .DEPTH(4)) u_c (
    .clk(clk), .rst(c_rst), .en(c_en), .tok_valid(c_tok_valid), .tok_ready(c_tok_ready),
    .tok_type(c_tok_type), .tok_payload(c_tok_payload), .resume(c_resume), .out_data(c_out_data),
    .out_valid(c_out_valid), .out_sob(c_out_sob), .out_eds(c_out_eds), .fifo_level(c_fifo_level));
  pcie_framing_token_scheduler #(.LANES(2), .DEPTH(8)) u_d (
    .clk(clk), .rst(d_rst), .en(d_en), .tok_valid(d_tok_valid), .tok_ready(d_tok_ready),
    .tok_type(d_tok_type), .tok_payload(d_tok_payload), .resume(d_resume), .out_data(d_out_data),
    .out_valid(d_out_valid), .out_sob(d_out_sob), .out_eds(d_out_eds), .fifo_level(d_fifo_level));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({a_out_valid, a_out_sob, a_out_eds} !== 3'b000 || a_out_data !== '0 || a_fifo_level !== 4'd0 || a_tok_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_a: got v=%b s=%b e=%b data=%h lvl=%0d rdy=%b, want zeros, rdy=1", a_out_valid, a_out_sob, a_out_eds, a_out_data, a_fifo_level, a_tok_ready);
    end
    n_tests++;
    if ({b_out_valid, b_out_sob, b_out_eds} !== 3'b000 || b_out_data !== '0 || b_fifo_level !== 4'd0 || b_tok_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_b: got v=%b s=%b e=%b data=%h lvl=%0d rdy=%b, want zeros, rdy=1", b_out_valid, b_out_sob, b_out_eds, b_out_data, b_fifo_level, b_tok_ready);
    end
    n_tests++;
    if ({c_out_valid, c_out_sob, c_out_eds} !== 3'b000 || c_out_data !== '0 || c_fifo_level !== 3'd0 || c_tok_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_c: got v=%b s=%b e=%b data=%h lvl=%0d rdy=%b, want zeros, rdy=1", c_out_valid, c_out_sob, c_out_eds, c_out_data, c_fifo_level, c_tok_ready);
    end
    n_tests++;
    if ({d_out_valid, d_out_sob, d_out_eds} !== 3'b000 || d_out_data !== '0 || d_fifo_level !== 4'd0 || d_tok_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_d: got v=%b s=%b e=%b data=%h lvl=%0d rdy=%b, want zeros, rdy=1", d_out_valid, d_out_sob, d_out_eds, d_out_data, d_fifo_level, d_tok_ready);
    end
    $display("[TB] reset checked on all instances");
  endtask

  task automatic test_stp_x16();
    exp_t e;
    a_tok_valid = 1'b1; a_tok_type = 2'd0; a_tok_payload = 32'h12345670; a_en = 1'b0;
    tick();
    a_tok_valid = 1'b0;
    n_tests++;
    if (a_fifo_level !== 4'd1) begin n_fail++; $display("FAIL stp16_level_push: got %0d want 1", a_fifo_level); end
    sb.push_back('{data: {96'h0, 32'h1234567F}, sob: 1'b1, eds: 1'b0});
    a_en = 1'b1;
    tick();
    a_en = 1'b0;
    n_tests++;
    if (!a_out_valid || sb.size() == 0) begin
      n_fail++; $display("FAIL stp16_out: got valid=%b want 1 with queued entry", a_out_valid);
    end else begin
      e = sb.pop_front();
      if (a_out_data !== e.data || a_out_sob !== e.sob || a_out_eds !== e.eds) begin
        n_fail++; $display("FAIL stp16_out: got data=%h sob=%b eds=%b want data=%h sob=%b eds=%b", a_out_data, a_out_sob, a_out_eds, e.data, e.sob, e.eds);
      end
    end
    n_tests++;
    if (a_fifo_level !== 4'd0) begin n_fail++; $display("FAIL stp16_level_pop: got %0d want 0", a_fifo_level); end
    $display("[TB] x16 single STP: data=%h sob=%b", a_out_data, a_out_sob);
  endtask

  task automatic test_back_to_back_x16();
    exp_t e;
    logic [1:0]  types [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic [31:0] pays  [4] = '{32'h44332210, 32'hBBAA0000, 32'h00000000, 32'h88776650};
    a_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a_tok_valid = 1'b1; a_tok_type = types[k]; a_tok_payload = pays[k];
      tick();
    end
    a_tok_valid = 1'b0;
    n_tests++;
    if (a_fifo_level !== 4'd4) begin n_fail++; $display("FAIL b2b16_level_fill: got %0d want 4", a_fifo_level); end
    sb.push_back('{data: 128'h8877665F_C0C0C0C0_BBAAACF0_4433221F, sob: 1'b0, eds: 1'b0});
    a_en = 1'b1;
    tick();
    a_en = 1'b0;
    n_tests++;
    if (!a_out_valid || sb.size() == 0) begin
      n_fail++; $display("FAIL b2b16_out: got valid=%b want 1", a_out_valid);
    end else begin
      e = sb.pop_front();
      if (a_out_data !== e.data || a_out_sob !== e.sob || a_out_eds !== e.eds) begin
        n_fail++; $display("FAIL b2b16_out: got data=%h sob=%b eds=%b want data=%h sob=%b eds=%b", a_out_data, a_out_sob, a_out_eds, e.data, e.sob, e.eds);
      end
    end
    n_tests++;
    if (a_fifo_level !== 4'd0) begin n_fail++; $display("FAIL b2b16_level_drain: got %0d want 0", a_fifo_level); end
    $display("[TB] x16 four tokens in one cycle: data=%h", a_out_data);
  endtask

  task automatic test_eds_x8();
    exp_t e;
    for (int c = 0; c < 16; c++)
      sb.push_back('{data: (c == 15) ? {64'h0, 32'h0090801F, 32'h0} : 128'h0, sob: (c == 0), eds: (c == 15)});
    b_en = 1'b1;
    for (int c = 0; c < 16; c++) begin
      b_tok_valid   = (c == 2) || (c == 3);
      b_tok_type    = (c == 2) ? 2'd3 : 2'd0;
      b_tok_payload = (c == 2) ? 32'h0 : 32'hCAFEBAB0;
      tick();
      n_tests++;
      if (!b_out_valid || sb.size() == 0) begin
        n_fail++; $display("FAIL eds8_sym%0d: got valid=%b want 1", c, b_out_valid);
      end else begin
        e = sb.pop_front();
        if (b_out_data !== e.data[63:0] || b_out_sob !== e.sob || b_out_eds !== e.eds) begin
          n_fail++; $display("FAIL eds8_sym%0d: got data=%h sob=%b eds=%b want data=%h sob=%b eds=%b", c, b_out_data, b_out_sob, b_out_eds, e.data[63:0], e.sob, e.eds);
        end
      end
      $display("[TB] x8 sym %0d: data=%h eds=%b", c, b_out_data, b_out_eds);
    end
    b_tok_valid = 1'b0;
    for (int h = 0; h < 4; h++) begin
      b_resume = (h == 3);
      tick();
      n_tests++;
      if (b_out_valid !== 1'b0 || b_out_eds !== 1'b0 || b_out_data !== '0) begin
        n_fail++; $display("FAIL eds8_hold%0d: got valid=%b eds=%b data=%h want 0 0 0", h, b_out_valid, b_out_eds, b_out_data);
      end
    end
    b_resume = 1'b0;
    n_tests++;
    if (b_fifo_level !== 4'd1) begin n_fail++; $display("FAIL eds8_stp_queued: got level %0d want 1", b_fifo_level); end
    sb.push_back('{data: {96'h0, 32'hCAFEBABF}, sob: 1'b1, eds: 1'b0});
    tick();
    b_en = 1'b0;
    n_tests++;
    if (!b_out_valid || sb.size() == 0) begin
      n_fail++; $display("FAIL eds8_resume: got valid=%b want 1", b_out_valid);
    end else begin
      e = sb.pop_front();
      if (b_out_data !== e.data[63:0] || b_out_sob !== e.sob) begin
        n_fail++; $display("FAIL eds8_resume: got data=%h sob=%b want data=%h sob=%b", b_out_data, b_out_sob, e.data[63:0], e.sob);
      end
    end
    $display("[TB] x8 after resume: data=%h sob=%b", b_out_data, b_out_sob);
  endtask

  task automatic test_en_stall_x1();
    logic [7:0] b;
    c_en = 1'b0; c_tok_valid = 1'b1; c_tok_type = 2'd0; c_tok_payload = 32'hDDCCBBA0;
    tick();
    c_tok_valid = 1'b0;
    sb_b.push_back(8'hAF); sb_b.push_back(8'hBB); sb_b.push_back(8'hCC); sb_b.push_back(8'hDD);
    for (int k = 0; k < 6; k++) begin
      c_en = en_pat[k];
      tick();
      n_tests++;
      if (en_pat[k]) begin
        if (!c_out_valid || sb_b.size() == 0) begin
          n_fail++; $display("FAIL stall1_cyc%0d: got valid=%b want 1", k, c_out_valid);
        end else begin
          b = sb_b.pop_front();
          if (c_out_data !== b || c_out_sob !== (c_sym == 0)) begin
            n_fail++; $display("FAIL stall1_cyc%0d: got byte=%h sob=%b want byte=%h sob=%b", k, c_out_data, c_out_sob, b, (c_sym == 0));
          end
        end
        c_sym = (c_sym + 1) % 16;
      end else if (c_out_valid !== 1'b0) begin
        n_fail++; $display("FAIL stall1_cyc%0d: got valid=%b want 0", k, c_out_valid);
      end
      $display("[TB] x1 en=%b valid=%b byte=%h", en_pat[k], c_out_valid, c_out_data);
    end
    c_en = 1'b0;
  endtask

  task automatic test_fifo_full_x1();
    logic [7:0] b;
    int n_acc = 0;
    int guard = 0;
    c_en = 1'b0; c_tok_valid = 1'b1; c_tok_type = 2'd0;
    for (int k = 0; k < 6; k++) begin
      c_tok_payload = {8'(n_acc), 8'h5A, 8'hA5, 8'h00};
      n_tests++;
      if (c_tok_ready !== (n_acc < 4)) begin
        n_fail++; $display("FAIL full1_ready%0d: got %b want %b", k, c_tok_ready, (n_acc < 4));
      end
      tick();
      if (n_acc < 4) begin
        sb_b.push_back(8'h0F); sb_b.push_back(8'hA5); sb_b.push_back(8'h5A); sb_b.push_back(8'(n_acc));
        n_acc++;
      end
      $display("[TB] x1 fill step %0d level=%0d", k, c_fifo_level);
    end
    // First latch pops one entry; ready returns the following cycle.
    c_tok_payload = {8'(n_acc), 8'h5A, 8'hA5, 8'h00};
    c_en = 1'b1;
    for (int p = 0; p < 2; p++) begin
      tick();
      if (p == 1) begin
        sb_b.push_back(8'h0F); sb_b.push_back(8'hA5); sb_b.push_back(8'h5A); sb_b.push_back(8'(n_acc));
        n_acc++;
        c_tok_valid = 1'b0;
      end
      n_tests++;
      if (c_tok_ready !== (p == 0) || c_fifo_level !== ((p == 0) ? 3'd3 : 3'd4)) begin
        n_fail++; $display("FAIL full1_reassert%0d: got rdy=%b lvl=%0d want rdy=%b lvl=%0d", p, c_tok_ready, c_fifo_level, (p == 0), (p == 0) ? 3 : 4);
      end
      n_tests++;
      b = (sb_b.size() > 0) ? sb_b.pop_front() : 8'hxx;
      if (c_out_valid !== 1'b1 || c_out_data !== b || c_out_sob !== (c_sym == 0)) begin
        n_fail++; $display("FAIL full1_byte_p%0d: got v=%b byte=%h sob=%b want byte=%h sob=%b", p, c_out_valid, c_out_data, c_out_sob, b, (c_sym == 0));
      end
      c_sym = (c_sym + 1) % 16;
    end
    while (sb_b.size() > 0 && guard < 40) begin
      tick();
      guard++;
      b = sb_b.pop_front();
      n_tests++;
      if (c_out_valid !== 1'b1 || c_out_data !== b || c_out_sob !== (c_sym == 0)) begin
        n_fail++; $display("FAIL full1_drain%0d: got v=%b byte=%h sob=%b want byte=%h sob=%b", guard, c_out_valid, c_out_data, c_out_sob, b, (c_sym == 0));
      end
      c_sym = (c_sym + 1) % 16;
    end
    c_en = 1'b0;
    n_tests++;
    if (sb_b.size() != 0 || c_fifo_level !== 3'd0 || n_acc != 5) begin
      n_fail++; $display("FAIL full1_end: got left=%0d lvl=%0d acc=%0d want 0 0 5", sb_b.size(), c_fifo_level, n_acc);
    end
    $display("[TB] x1 full/drain done, %0d tokens", n_acc);
  endtask

  task automatic test_reset_mid_dw_x2();
    exp_t e;
    d_en = 1'b0; d_tok_valid = 1'b1; d_tok_type = 2'd0; d_tok_payload = 32'h44332210;
    tick();
    d_tok_payload = 32'h99999990; d_en = 1'b1;
    sb.push_back('{data: 128'h221F, sob: 1'b1, eds: 1'b0});
    tick();
    d_tok_valid = 1'b0;
    n_tests++;
    e = sb.pop_front();
    if (d_out_valid !== 1'b1 || d_out_data !== e.data[15:0] || d_out_sob !== e.sob || d_fifo_level !== 4'd1) begin
      n_fail++; $display("FAIL rst2_half: got v=%b data=%h sob=%b lvl=%0d want 1 %h %b 1", d_out_valid, d_out_data, d_out_sob, d_fifo_level, e.data[15:0], e.sob);
    end
    d_rst = 1'b1;
    tick();
    d_rst = 1'b0;
    n_tests++;
    if ({d_out_valid, d_out_sob, d_out_eds} !== 3'b000 || d_out_data !== '0 || d_fifo_level !== 4'd0 || d_tok_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst2_cleared: got v=%b s=%b e=%b data=%h lvl=%0d rdy=%b want zeros rdy=1", d_out_valid, d_out_sob, d_out_eds, d_out_data, d_fifo_level, d_tok_ready);
    end
    d_en = 1'b0; d_tok_valid = 1'b1; d_tok_payload = 32'h88776650;
    tick();
    d_tok_valid = 1'b0; d_en = 1'b1;
    sb.push_back('{data: 128'h665F, sob: 1'b1, eds: 1'b0});
    sb.push_back('{data: 128'h8877, sob: 1'b0, eds: 1'b0});
    for (int k = 0; k < 2; k++) begin
      tick();
      n_tests++;
      e = sb.pop_front();
      if (d_out_valid !== 1'b1 || d_out_data !== e.data[15:0] || d_out_sob !== e.sob) begin
        n_fail++; $display("FAIL rst2_next%0d: got v=%b data=%h sob=%b want 1 %h %b", k, d_out_valid, d_out_data, d_out_sob, e.data[15:0], e.sob);
      end
      $display("[TB] x2 after reset: data=%h sob=%b", d_out_data, d_out_sob);
    end
    d_en = 1'b0;
  endtask

  initial begin
    {a_rst, b_rst, c_rst, d_rst} = 4'hF;
    {a_en, b_en, c_en, d_en} = 4'h0;
    {a_tok_valid, b_tok_valid, c_tok_valid, d_tok_valid} = 4'h0;
    {a_resume, b_resume, c_resume, d_resume} = 4'h0;
    a_tok_type = 2'd0; b_tok_type = 2'd0; c_tok_type = 2'd0; d_tok_type = 2'd0;
    a_tok_payload = '0; b_tok_payload = '0; c_tok_payload = '0; d_tok_payload = '0;
    tick();
    tick();
    test_reset();
    {a_rst, b_rst, c_rst, d_rst} = 4'h0;
    test_stp_x16();
    test_back_to_back_x16();
    test_eds_x8();
    test_en_stall_x1();
    test_fifo_full_x1();
    test_reset_mid_dw_x2();
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pcie_framing_token_scheduler.md
Name: pcie_framing_token_scheduler

Overview:
- Parametrised Gen3 (128b/130b) framing-token scheduler for x1/x2/x4/x8/x16 links.
- Queues framing-token requests (STP, SDP, EDB, EDS) and places each one on a 4-byte (DW) aligned lane boundary, i.e. lanes 4N. Unused DW slots are filled with IDL.
- Tracks 16-symbol data-block boundaries. EDS is forced into the final DW of a block, after which the block holds until an ordered set has been sent.
- Sits between the DLL/TL token-request path and the per-lane scrambler/gearbox.

Parameters:
- LANES, 16, link width; legal values 1, 2, 4, 8, 16.
- DEPTH, 8, token FIFO depth; power of 2, minimum 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- en  in  1  symbol-time advance from gearbox; low = stall (outputs and state hold, nothing consumed)
- tok_valid  in  1  token request valid
- tok_ready  out  1  FIFO not full
- tok_type  in  2  0=STP, 1=SDP, 2=EDB, 3=EDS
- tok_payload  in  32  token bytes; [7:0] = byte 0, transmitted first on the lowest lane
- resume  in  1  pulse; ordered set done, start a new data block
- out_data  out  LANES*8  symbols for this symbol time; lane k = [8k+:8]
- out_valid  out  1  out_data carries data-block symbols
- out_sob  out  1  first symbol time of a data block
- out_eds  out  1  the cycle that completes the EDS DW
- fifo_level  out  $clog2(DEPTH+1)  entries currently queued

Behaviour:
- Reset is synchronous and active-high: out_data=0, out_valid=0, out_sob=0, out_eds=0, FIFO empty, sym_cnt=0, dw byte pointer=0, state=RUN.
- All outputs are registered.
- Input handshake:
  - A token is accepted when tok_valid && tok_ready.
  - tok_ready = (count<DEPTH). It is independent of tok_valid and of any same-cycle pop.
  - Push and pop in the same cycle are allowed.
  - Latency: a token accepted in cycle t appears on out_data no earlier than the en-cycle after t.
- DW formation:
  - STP = payload bytes 0..3, with byte0[3:0] forced to 4'hF.
  - SDP = F0, AC, payload byte2, payload byte3.
  - EDB = C0 C0 C0 C0.
  - EDS = 1F 80 90 00.
  - IDL = 00 00 00 00.
- SLOTS = max(LANES/4, 1); DW_CYC = max(4/LANES, 1).
- LANES>=4, on each en cycle in RUN:
  - Slots are filled 0..SLOTS-1 in FIFO order. Up to SLOTS entries are popped per cycle.
  - A head EDS is placed only in slot SLOTS-1 when sym_cnt==15.
  - Otherwise that slot and all later slots in the cycle get IDL, and the EDS stays queued. This preserves strict token order.
- LANES<4:
  - A DW is latched from the FIFO head, or IDL if the FIFO is empty, when the byte pointer is 0.
  - It is emitted LANES bytes per en-cycle over DW_CYC cycles. The pop occurs at latch time.
  - EDS latches only if its final byte lands at sym_cnt==15, i.e. at sym_cnt==16-DW_CYC. Otherwise an IDL DW is latched.
- sym_cnt counts 0..15 on en cycles in RUN and wraps to 0. out_sob=1 when the emitted symbol time has sym_cnt==0.
- State machine:
  - RUN: out_valid=1 on en cycles. When the EDS DW completes: out_eds=1 for that cycle, go to HOLD, sym_cnt<=0.
  - HOLD: out_valid=0, out_data=0, no pops; tok_ready still follows FIFO count. resume -> RUN. The next en cycle is sob.
  - resume while in RUN is ignored.
  - An en=0 cycle in RUN drives out_valid=0 and holds all state.
- Reset mid-DW (LANES<4): the partial DW is discarded and the pointer is cleared. Tokens queued before reset are lost.
- FIFO empty gives IDL; FIFO full gives tok_ready=0. A full FIFO with a simultaneous pop still presents ready=0 that cycle.
- fifo_level reflects the registered count after the current cycle's push/pop.

Decomposition:
- Package pcie_framing_pkg holds:
  - token-type enum
  - constants SDP_B0=8'hF0, SDP_B1=8'hAC, EDB_B=8'hC0, EDS_DW=32'h0090801F (byte order per tok_payload), IDL_B=8'h00
  - SYMS_PER_BLOCK=16
  - a function building the 32-bit DW from type+payload
- Sub-module pcie_tok_fifo: synchronous FIFO, DEPTH x 34 bits, single push, multi-pop (pop count 0..SLOTS), peek of the first SLOTS entries.

Test Plan:
- LANES=16, reset, one STP with payload 32'h12345670, en=1 -> next cycle lanes0-3 = 7F 56 34 12, lanes4-15 = 00, out_sob=1.
- LANES=16, en=0 while 4 tokens (STP,SDP payload 32'hBBAA0000,EDB,STP) are pushed, then en=1 -> one cycle carries all four slots in order: lanes4-7 = F0 AC AA BB, lanes8-11 = C0x4; fifo_level goes to 0.
- LANES=8, EDS pushed at sym_cnt=3 followed by an STP -> IDL until sym_cnt=15, lanes4-7 = 1F 80 90 00, out_eds=1, then out_valid=0. The STP stays queued until resume, then appears with out_sob=1.
- LANES=1, STP 32'hDDCCBBA0 with en toggling 1,0,1,1,0,1 -> bytes AF, BB, CC, DD emitted only on en cycles, in order.
- DEPTH=4, LANES=1, tok_valid held high -> tok_ready=0 after 4 accepts. It reasserts the cycle after the first DW latch pops. No token is lost or duplicated.
- LANES=2, assert rst after the first half of an STP DW -> all outputs 0 next cycle, FIFO empty, and the next token starts at byte 0.
